// File: rtl/keccak_pkg.sv
// Shared constants and types for the slice-serial Keccak rho engine.
// Offsets are raw; each user reduces them modulo its own lane width.
package keccak_pkg;

    localparam int LANES = 25;

    localparam int RHO_OFFSETS [0:24] = '{
         0,  1, 62, 28, 27,
        36, 44,  6, 55, 20,
         3, 10, 43, 25, 39,
        41, 45, 15, 21,  8,
        18,  2, 61, 56, 14
    };

    typedef enum logic {
        LOAD = 1'b0,
        EMIT = 1'b1
    } rho_state_e;

endpackage

// File: rtl/keccak_rho_stream_if.sv
// Slice stream bundle: input slice handshake plus rotated output handshake.
// Master is the producer/consumer side, slave is the rho engine.
interface keccak_rho_stream_if;
    import keccak_pkg::*;

    logic             inv;
    logic             in_valid;
    logic             in_ready;
    logic [LANES-1:0] in_slice;
    logic             out_valid;
    logic             out_ready;
    logic [LANES-1:0] out_slice;
    logic             out_last;

    modport master (
        output inv,
        output in_valid,
        output in_slice,
        output out_ready,
        input  in_ready,
        input  out_valid,
        input  out_slice,
        input  out_last
    );

    modport slave (
        input  inv,
        input  in_valid,
        input  in_slice,
        input  out_ready,
        output in_ready,
        output out_valid,
        output out_slice,
        output out_last
    );

endinterface

// File: rtl/rho_lane_mux.sv
// Picks one bit of a lane column for the slice being emitted.
// Index arithmetic wraps naturally in ZW bits, so W must be a power of two.
module rho_lane_mux #(
    parameter int W  = 64,
    parameter int ZW = $clog2(W)
) (
    input  logic [ZW-1:0] rcnt,
    input  logic [ZW-1:0] off,
    input  logic          mode,
    input  logic [W-1:0]  col,
    output logic          sel_bit
);

    logic [ZW-1:0] idx;

    assign idx     = mode ? (rcnt + off) : (rcnt - off);
    assign sel_bit = col[idx];

endmodule

// File: rtl/keccak_rho_stream.sv
// Slice-serial Keccak rho: buffers a full W-slice state, then streams
// W rotated slices out; forward or inverse rotation chosen per frame.
module keccak_rho_stream
    import keccak_pkg::*;
#(
    parameter int W  = 64,
    parameter int ZW = $clog2(W)
) (
    input  logic                clk,
    input  logic                rst,
    keccak_rho_stream_if.slave  st,
    output logic                busy
);

    localparam logic [ZW-1:0] LAST_Z = ZW'(W - 1);

    rho_state_e       state_q;
    rho_state_e       state_d;
    logic [ZW-1:0]    wcnt_q;
    logic [ZW-1:0]    rcnt_q;
    logic             mode_q;
    logic [LANES-1:0] mem_q [W];
    logic [LANES-1:0] slice_rot;
    logic             in_rdy;
    logic             out_vld;
    logic             acc;
    logic             xfer;

    assign acc  = st.in_valid & in_rdy;
    assign xfer = out_vld & st.out_ready;

    always_comb begin
        state_d = state_q;
        in_rdy  = 1'b0;
        out_vld = 1'b0;
        unique case (state_q)
            LOAD: begin
                in_rdy = 1'b1;
                if (st.in_valid && wcnt_q == LAST_Z)
                    state_d = EMIT;
            end
            EMIT: begin
                out_vld = 1'b1;
                if (st.out_ready && rcnt_q == LAST_Z)
                    state_d = LOAD;
            end
            default: state_d = LOAD;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= LOAD;
            wcnt_q  <= '0;
            rcnt_q  <= '0;
            mode_q  <= 1'b0;
            for (int z = 0; z < W; z++)
                mem_q[z] <= '0;
        end else begin
            state_q <= state_d;
            if (acc) begin
                mem_q[wcnt_q] <= st.in_slice;
                wcnt_q        <= wcnt_q + ZW'(1);
                if (wcnt_q == '0)
                    mode_q <= st.inv;
            end
            if (xfer)
                rcnt_q <= rcnt_q + ZW'(1);
        end
    end

    // Each lane sees its own bit column across all buffered slices.
    for (genvar i = 0; i < LANES; i++) begin : g_lane
        localparam logic [ZW-1:0] OFF = ZW'(RHO_OFFSETS[i] % W);
        logic [W-1:0] col;

        always_comb begin
            col = '0;
            for (int z = 0; z < W; z++)
                col[z] = mem_q[z][i];
        end

        rho_lane_mux #(
            .W  (W),
            .ZW (ZW)
        ) u_mux (
            .rcnt    (rcnt_q),
            .off     (OFF),
            .mode    (mode_q),
            .col     (col),
            .sel_bit (slice_rot[i])
        );
    end

    assign st.in_ready  = in_rdy;
    assign st.out_valid = out_vld;
    assign st.out_slice = slice_rot;
    assign st.out_last  = out_vld & (rcnt_q == LAST_Z);
    assign busy         = (state_q == EMIT) | (wcnt_q != '0);

endmodule

// File: tb/tb_keccak_rho_stream.sv
// Scoreboard bench for keccak_rho_stream at W=64 and W=8.
// Driver pushes expected slices; negedge monitors pop and compare.
module tb_keccak_rho_stream;
    import keccak_pkg::*;

    typedef struct packed {
        logic [24:0] s;
        logic        last;
    } exp_t;

    typedef logic [24:0] frame_t [64];

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic busy64;
    logic busy8;

    always #5 clk = ~clk;

    keccak_rho_stream_if i64 ();
    keccak_rho_stream_if i8 ();

    keccak_rho_stream #(.W(64)) u64 (
        .clk  (clk),
        .rst  (rst_n),
        .st   (i64),
        .busy (busy64)
    );

    keccak_rho_stream #(.W(8)) u8 (
        .clk  (clk),
        .rst  (rst_n),
        .st   (i8),
        .busy (busy8)
    );

    int checks = 0;
    int errors = 0;
    exp_t q64 [$];
    exp_t q8 [$];
    logic [24:0] cap [$];
    bit cap_en = 1'b0;
    bit stalled64 = 1'b0;
    logic [24:0] hold64;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            if (i64.out_valid) begin
                chk("in_ready_in_emit64", i64.in_ready, 0);
                if (stalled64)
                    chk("stall_hold64", i64.out_slice, hold64);
                if (i64.out_ready) begin
                    stalled64 = 1'b0;
                    if (q64.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL extra_slice64: got %h expected none",
                                 i64.out_slice);
                    end else begin
                        exp_t e;
                        e = q64.pop_front();
                        chk("slice64", i64.out_slice, e.s);
                        chk("last64", i64.out_last, e.last);
                        if (cap_en)
                            cap.push_back(i64.out_slice);
                    end
                end else begin
                    stalled64 = 1'b1;
                    hold64 = i64.out_slice;
                end
            end else begin
                stalled64 = 1'b0;
                chk("last_idle64", i64.out_last, 0);
            end
        end else begin
            stalled64 = 1'b0;
        end
    end

    always @(negedge clk) begin
        if (rst_n && i8.out_valid) begin
            chk("in_ready_in_emit8", i8.in_ready, 0);
            if (i8.out_ready) begin
                if (q8.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL extra_slice8: got %h expected none",
                             i8.out_slice);
                end else begin
                    exp_t e;
                    e = q8.pop_front();
                    chk("slice8", i8.out_slice, e.s);
                    chk("last8", i8.out_last, e.last);
                end
            end
        end
    end

    function automatic void rho_ref(input frame_t f, input int w,
                                    input bit inv, output frame_t o);
        for (int z = 0; z < 64; z++)
            o[z] = '0;
        for (int z = 0; z < w; z++) begin
            for (int i = 0; i < 25; i++) begin
                int r;
                int src;
                r = RHO_OFFSETS[i] % w;
                src = inv ? (z + r) % w : (z - r + w) % w;
                o[z][i] = f[src][i];
            end
        end
    endfunction

    task automatic push(input int sel, input frame_t e, input int n);
        for (int z = 0; z < n; z++) begin
            exp_t x;
            x.s = e[z];
            x.last = (z == n - 1);
            if (sel == 0)
                q64.push_back(x);
            else
                q8.push_back(x);
        end
    endtask

    // inv is flipped after the first slice; the DUT must ignore that.
    task automatic send(input int sel, input frame_t f, input bit inv,
                        input int n);
        for (int z = 0; z < n; z++) begin
            int t;
            t = 0;
            if (sel == 0) begin
                i64.in_valid = 1'b1;
                i64.in_slice = f[z];
                i64.inv = (z == 0) ? inv : ~inv;
            end else begin
                i8.in_valid = 1'b1;
                i8.in_slice = f[z];
                i8.inv = (z == 0) ? inv : ~inv;
            end
            while (!(sel == 0 ? i64.in_ready : i8.in_ready) && t < 1000) begin
                @(posedge clk);
                #1;
                t++;
            end
            if (t >= 1000) begin
                checks++;
                errors++;
                $display("FAIL in_ready_timeout: got 0 expected 1");
            end
            @(posedge clk);
            #1;
        end
        i64.in_valid = 1'b0;
        i8.in_valid = 1'b0;
    endtask

    task automatic drain();
        int t;
        t = 0;
        while ((q64.size() != 0 || q8.size() != 0) && t < 2000) begin
            @(posedge clk);
            #1;
            t++;
        end
        chk("drain_q64", q64.size(), 0);
        chk("drain_q8", q8.size(), 0);
        @(posedge clk);
        #1;
    endtask

    frame_t f;
    frame_t e;
    frame_t rf;
    frame_t fb;

    task automatic clear_fe();
        for (int z = 0; z < 64; z++) begin
            f[z] = '0;
            e[z] = '0;
        end
    endtask

    initial begin
        i64.in_valid = 1'b0;
        i64.in_slice = '0;
        i64.inv = 1'b0;
        i64.out_ready = 1'b1;
        i8.in_valid = 1'b0;
        i8.in_slice = '0;
        i8.inv = 1'b0;
        i8.out_ready = 1'b1;

        repeat (3) @(posedge clk);
        #1;
        chk("rst_in_ready64", i64.in_ready, 1);
        chk("rst_out_valid64", i64.out_valid, 0);
        chk("rst_out_last64", i64.out_last, 0);
        chk("rst_busy64", busy64, 0);
        chk("rst_out_slice64", i64.out_slice, 0);
        chk("rst_in_ready8", i8.in_ready, 1);
        chk("rst_out_slice8", i8.out_slice, 0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        clear_fe();
        f[0] = 25'h2;
        e[1] = 25'h2;
        push(0, e, 64);
        send(0, f, 1'b0, 64);
        chk("latency64", i64.out_valid, 1);
        drain();

        clear_fe();
        f[0] = 25'h4;
        e[62] = 25'h4;
        push(0, e, 64);
        send(0, f, 1'b0, 64);
        drain();

        clear_fe();
        f[0] = 25'h4;
        e[2] = 25'h4;
        push(0, e, 64);
        send(0, f, 1'b1, 64);
        drain();

        clear_fe();
        f[0] = 25'h4;
        e[6] = 25'h4;
        push(1, e, 8);
        send(1, f, 1'b0, 8);
        chk("latency8", i8.out_valid, 1);
        drain();

        clear_fe();
        f[0] = 25'h4;
        e[2] = 25'h4;
        push(1, e, 8);
        send(1, f, 1'b1, 8);
        drain();

        for (int z = 0; z < 64; z++)
            rf[z] = 25'($urandom());
        rho_ref(rf, 64, 1'b0, e);
        push(0, e, 64);
        send(0, rf, 1'b0, 64);
        chk("busy_emit64", busy64, 1);
        @(posedge clk);
        #1;
        i64.out_ready = 1'b0;
        repeat (2) begin
            @(posedge clk);
            #1;
        end
        i64.out_ready = 1'b1;
        drain();

        for (int z = 0; z < 64; z++)
            rf[z] = 25'($urandom());
        rho_ref(rf, 64, 1'b0, e);
        push(0, e, 64);
        cap.delete();
        cap_en = 1'b1;
        send(0, rf, 1'b0, 64);
        drain();
        cap_en = 1'b0;
        chk("capture_count", cap.size(), 64);
        for (int z = 0; z < 64; z++)
            fb[z] = (z < cap.size()) ? cap[z] : '0;
        push(0, rf, 64);
        send(0, fb, 1'b1, 64);
        drain();

        for (int z = 0; z < 64; z++)
            rf[z] = 25'($urandom()) | 25'h1;
        send(0, rf, 1'b1, 20);
        chk("busy_partial64", busy64, 1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("midrst_in_ready64", i64.in_ready, 1);
        chk("midrst_out_valid64", i64.out_valid, 0);
        chk("midrst_busy64", busy64, 0);
        chk("midrst_out_slice64", i64.out_slice, 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        clear_fe();
        f[0] = 25'h2;
        e[1] = 25'h2;
        push(0, e, 64);
        send(0, f, 1'b0, 64);
        drain();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
